x32_approx_mul_seq: RTL
=======================

Name: x32_approx_mul_seq

Overview:
Sequential shift-and-add 32x32 multiplier that time-multiplexes one x32_approx_add instance over up to 32 cycles. It returns the low 32 bits of the product. Setting N16>0 makes the low N16 bits of every partial-sum addition approximate. It sits between the PCPI-style multiply front end and the adder datapath, using a valid/ready handshake on both sides. The controller owns operand latching, step sequencing, early termination and result hold.

Parameters:
N16, 0, number of approximate LSBs; passed unchanged to the internal x32_approx_add (0 = fully exact).
EARLY_EXIT, 1, 1 = stop as soon as the remaining multiplier bits are zero; 0 = always run 32 steps.

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  operands valid
in_ready  out  1  block can accept operands
in_a  in  32  multiplicand
in_b  in  32  multiplier
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_prod  out  32  low 32 bits of the (approximate) product
out_cout  out  1  sticky OR of the adder cout over all performed additions
out_steps  out  6  number of RUN steps executed (1..32)

Behaviour:
- States: IDLE, RUN, DONE. Reset forces IDLE.
- Reset values: out_valid=0, out_prod=0, out_cout=0, out_steps=0. Internal mcand, mplier and cnt are cleared to 0.
- in_ready = (state==IDLE) && !reset. It is combinational and 0 in RUN and DONE, so there is no operand overlap.
- IDLE: when in_valid && in_ready, latch mcand=in_a, mplier=in_b, acc=0, cout_sticky=0, cnt=0, then go to RUN. in_a and in_b are ignored at all other times.
- RUN, one step per cycle:
  - The adder computes acc + mcand with cin tied 0.
  - If mplier[0]=1: acc <= adder sum and cout_sticky |= adder cout. If mplier[0]=0, acc and cout_sticky are unchanged.
  - mcand <= mcand<<1, discarding bit 31. mplier <= mplier>>1 with zero fill. cnt <= cnt+1.
  - Go to DONE after the step where cnt==31, or where EARLY_EXIT=1 and mplier[31:1]==0 (tested before the shift).
  - RUN always executes at least one step, including when in_b=0.
- Step count k = 32 when EARLY_EXIT=0. When EARLY_EXIT=1, k = max(1, index of highest set bit of in_b + 1).
- Latency: with handshake in cycle c0, RUN occupies c1..ck and out_valid is first high in cycle c0+k+1.
- On entry to DONE, register out_prod=acc, out_cout=cout_sticky, out_steps=k.
- DONE: out_valid=1. out_prod, out_cout and out_steps stay stable until out_ready=1. On out_valid && out_ready, go to IDLE and drop out_valid the next cycle. The result registers keep their last values after the transfer.
- out_ready is don't-care outside DONE. There is no back-to-back fast path: at least 1 IDLE cycle separates operations.
- Arithmetic: all values are modulo 2^32. out_cout is a diagnostic flag, not a full overflow indicator; bits shifted out of mcand are not reported.
- With N16>0, out_prod must be bit-exact to a model that chains the x1_approx_add / x1_accu_add cell behaviour per step. Exactness versus a*b is not required.
- Reset asserted in RUN or DONE: abort next edge into IDLE. No out_valid is produced for the aborted operation and outputs return to reset values.
- Reset asserted in the same cycle as in_valid: the operands are not accepted.

Test Plan:
1. N16=0, EARLY_EXIT=1, in_a=3, in_b=5 -> out_prod=15, out_steps=3, out_cout=0, out_valid first high 4 cycles after the handshake cycle.
2. N16=0, in_a=0xFFFFFFFF, in_b=0xFFFFFFFF -> out_prod=0x00000001, out_steps=32, out_cout=1, out_valid at c0+33.
3. N16=0, in_a=0x1234, in_b=0 -> out_prod=0, out_steps=1, out_cout=0, out_valid at c0+2.
4. Back-pressure: after test 1, hold out_ready=0 for 5 cycles while pulsing in_valid with new operands -> out_valid, out_prod=15 and out_steps=3 stable; in_ready=0; new operands ignored. Raise out_ready -> IDLE next cycle, in_ready=1.
5. Reset mid-operation: in_a=7, in_b=0x80000000; assert reset in cycle c0+10 -> next cycle state IDLE, out_valid=0, outputs at reset values. After release, in_a=7, in_b=6 -> out_prod=42, out_steps=3.
6. EARLY_EXIT=0, in_a=3, in_b=5 -> out_prod=15, out_steps=32, out_valid at c0+33. N16=8 random sweep (1000 operand pairs) -> out_prod matches the per-step cell-accurate model.

Source files
------------

// File: rtl/x32_approx_mul_seq.sv
// ---------------------------------------------------------------------------
// x32_approx_mul_seq
// Sequential shift-and-add 32x32 multiplier returning the low 32 bits of the
// product. A single x32_approx_add instance is reused for every partial-sum
// addition. Its low N16 bits use approximate cells.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   reset      synchronous, active-high reset
//   in_valid   operands valid
//   in_ready   block can accept operands (IDLE and not in reset)
//   in_a       multiplicand
//   in_b       multiplier
//   out_valid  result valid (held in DONE until out_ready)
//   out_ready  consumer accepts result
//   out_prod   low 32 bits of the (approximate) product
//   out_cout   sticky OR of adder cout over all performed additions
//   out_steps  number of RUN steps executed (1..32)
//
// Also contains the adder datapath:
//   x1_accu_add    exact full-adder cell
//   x1_approx_add  approximate cell: exact carry, sum = ~carry
//   x32_approx_add 32-bit ripple adder with approximate low N16 bits
// ---------------------------------------------------------------------------

module x1_accu_add (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// The carry is kept exact so that the error stays confined to the low bits.
// The sum is approximated as the inverted carry. This is correct for 6 of the
// 8 input combinations and wrong only for 000 and 111.
module x1_approx_add (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic carry;
    assign carry = (a & b) | (cin & (a | b));
    assign cout  = carry;
    assign sum   = ~carry;
endmodule

module x32_approx_add #(
    parameter int N16 = 0
) (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [32:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[32];

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi = gi + 1) begin : g_bit
            if (gi < N16) begin : g_apx
                x1_approx_add u_cell (
                    .a   (a[gi]),
                    .b   (b[gi]),
                    .cin (carry[gi]),
                    .sum (sum[gi]),
                    .cout(carry[gi+1])
                );
            end else begin : g_acc
                x1_accu_add u_cell (
                    .a   (a[gi]),
                    .b   (b[gi]),
                    .cin (carry[gi]),
                    .sum (sum[gi]),
                    .cout(carry[gi+1])
                );
            end
        end
    endgenerate
endmodule

module x32_approx_mul_seq #(
    parameter int N16        = 0,
    parameter int EARLY_EXIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_prod,
    output logic        out_cout,
    output logic [5:0]  out_steps
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] mcand_reg;
    logic [31:0] mplier_reg;
    logic [31:0] acc_reg;
    logic        sticky_reg;
    logic [4:0]  cnt_reg;
    logic        out_valid_reg;
    logic [31:0] out_prod_reg;
    logic        out_cout_reg;
    logic [5:0]  out_steps_reg;

    logic [31:0] add_sum;
    logic        add_cout;
    logic [31:0] acc_next;
    logic        sticky_next;
    logic        last_step;

    x32_approx_add #(.N16(N16)) u_add (
        .a   (acc_reg),
        .b   (mcand_reg),
        .cin (1'b0),
        .sum (add_sum),
        .cout(add_cout)
    );

    // Partial sum is only taken when the current multiplier bit is set.
    assign acc_next    = mplier_reg[0] ? add_sum : acc_reg;
    assign sticky_next = sticky_reg | (mplier_reg[0] & add_cout);

    // The early-exit test uses the multiplier before this step's shift.
    assign last_step = (cnt_reg == 5'd31) ||
                       ((EARLY_EXIT != 0) && (mplier_reg[31:1] == 31'd0));

    assign in_ready  = (state_reg == IDLE) && !reset;
    assign out_valid = out_valid_reg;
    assign out_prod  = out_prod_reg;
    assign out_cout  = out_cout_reg;
    assign out_steps = out_steps_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            mcand_reg     <= 32'd0;
            mplier_reg    <= 32'd0;
            acc_reg       <= 32'd0;
            sticky_reg    <= 1'b0;
            cnt_reg       <= 5'd0;
            out_valid_reg <= 1'b0;
            out_prod_reg  <= 32'd0;
            out_cout_reg  <= 1'b0;
            out_steps_reg <= 6'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        mcand_reg  <= in_a;
                        mplier_reg <= in_b;
                        acc_reg    <= 32'd0;
                        sticky_reg <= 1'b0;
                        cnt_reg    <= 5'd0;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    acc_reg    <= acc_next;
                    sticky_reg <= sticky_next;
                    mcand_reg  <= {mcand_reg[30:0], 1'b0};
                    mplier_reg <= {1'b0, mplier_reg[31:1]};
                    cnt_reg    <= cnt_reg + 5'd1;
                    if (last_step) begin
                        // Capture this step's result directly so that DONE
                        // presents it in the same cycle out_valid rises.
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                        out_prod_reg  <= acc_next;
                        out_cout_reg  <= sticky_next;
                        out_steps_reg <= {1'b0, cnt_reg} + 6'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule
